// File: rtl/issue_queue_param.sv
// Age-ordered issue queue: circular buffer with NPORT push, issue and retire ports.
// Every entry is presented oldest first, with optional same-cycle visibility of pushes.
module issue_queue_param #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int WIDTH  = 32,
  parameter int NPORT  = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [NPORT-1:0]       push,
  input  logic [NPORT*WIDTH-1:0] push_data,
  output logic [NPORT-1:0]       push_ack,
  input  logic [NPORT-1:0]       pop,
  input  logic [NPORT*AW-1:0]    pop_key,
  input  logic [NPORT-1:0]       retire,
  output logic [DEPTH*WIDTH-1:0] ent_data,
  output logic [DEPTH*AW-1:0]    ent_idx,
  output logic [DEPTH-1:0]       ent_vld,
  output logic [AW:0]            free,
  output logic [AW:0]            count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW:0]      n_ack;
  logic [AW:0]      n_ret;

  assign count = count_q;
  assign free  = DEPTH_C - count_q;

  // Acks cover only the contiguous low run of requests that fits in the free
  // space; nothing is acked while reset or flush will discard it anyway.
  always_comb begin
    logic run;
    run      = 1'b1;
    push_ack = '0;
    n_ack    = '0;
    for (int i = 0; i < NPORT; i++) begin
      run = run & push[i];
      if (run && ((AW+1)'(i) < free) && !reset && !flush) begin
        push_ack[i] = 1'b1;
        n_ack       = n_ack + 1'b1;
      end
    end
  end

  always_comb begin
    logic run;
    run   = 1'b1;
    n_ret = '0;
    for (int i = 0; i < NPORT; i++) begin
      run = run & retire[i];
      if (run && (n_ret < count_q)) begin
        n_ret = n_ret + 1'b1;
      end
    end
  end

  // Pushes set valid first so an issue of a just-pushed slot can clear it.
  always_comb begin
    logic [AW-1:0] slot;
    logic [AW-1:0] key;
    logic [AW:0]   key_w;
    wr_ptr_d = wr_ptr_q + n_ack[AW-1:0];
    rd_ptr_d = rd_ptr_q + n_ret[AW-1:0];
    count_d  = count_q + n_ack - n_ret;
    data_d   = data_q;
    vld_d    = vld_q;
    slot     = '0;
    key      = '0;
    key_w    = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (push_ack[i]) begin
        slot         = wr_ptr_q + AW'(i);
        data_d[slot] = push_data[i*WIDTH +: WIDTH];
        vld_d[slot]  = 1'b1;
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      key   = pop_key[p*AW +: AW];
      key_w = {1'b0, key};
      if (pop[p] && ((key_w < count_q) ||
                     ((BYPASS != 0) && ((key_w - count_q) < n_ack)))) begin
        slot        = rd_ptr_q + key;
        vld_d[slot] = 1'b0;
      end
    end
    for (int k = 0; k < NPORT; k++) begin
      if ((AW+1)'(k) < n_ret) begin
        slot        = rd_ptr_q + AW'(k);
        vld_d[slot] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
    end
  end

  // Positions past the occupied range show the acked push that lands there;
  // since wr_ptr == rd_ptr + count, offset j - count is the push port number.
  always_comb begin
    logic [AW-1:0] idx;
    logic [AW:0]   pos;
    logic [AW:0]   off;
    ent_data = '0;
    ent_idx  = '0;
    ent_vld  = '0;
    idx      = '0;
    pos      = '0;
    off      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      idx = rd_ptr_q + AW'(j);
      pos = (AW+1)'(j);
      ent_idx[j*AW +: AW] = idx;
      if (pos < count_q) begin
        ent_vld[j]                = vld_q[idx];
        ent_data[j*WIDTH +: WIDTH] = data_q[idx];
      end else if (BYPASS != 0) begin
        off = pos - count_q;
        for (int p = 0; p < NPORT; p++) begin
          if (push_ack[p] && ((AW+1)'(p) == off)) begin
            ent_vld[j]                = 1'b1;
            ent_data[j*WIDTH +: WIDTH] = push_data[p*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// Bench for issue_queue_param (DEPTH=8, NPORT=2, BYPASS=1): age-ordered queue model
// predicts every cycle; retired payloads are checked against an in-order scoreboard.
module tb_issue_queue_param;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [1:0]  push, pop, retire, push_ack;
  logic [63:0] push_data;
  logic [5:0]  pop_key;
  logic [255:0] ent_data;
  logic [23:0] ent_idx;
  logic [7:0]  ent_vld;
  logic [3:0]  free, count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mq_data[$];
  bit          mq_vld[$];
  logic [31:0] sb_q[$];
  int          m_rd = 0;

  always #5 clk = ~clk;

  issue_queue_param #(.DEPTH(8), .AW(3), .WIDTH(32), .NPORT(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push(push), .push_data(push_data), .push_ack(push_ack),
    .pop(pop), .pop_key(pop_key), .retire(retire),
    .ent_data(ent_data), .ent_idx(ent_idx), .ent_vld(ent_vld),
    .free(free), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle, compare combinational and registered outputs, then advance.
  task automatic cycle(input logic [1:0] ps, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] pp, input logic [2:0] k0, input logic [2:0] k1,
                       input logic [1:0] rt, input logic fl, input logic rs);
    int sz, fr, nack, nret, key;
    bit run;
    logic [1:0]  eack;
    logic [7:0]  evld;
    logic [23:0] eidx;
    logic [31:0] edat;
    logic [31:0] d [2];
    d[0] = d0; d[1] = d1;
    push = ps; push_data = {d1, d0}; pop = pp; pop_key = {k1, k0};
    retire = rt; flush = fl; reset = rs;
    #1;
    sz = mq_data.size();
    fr = 8 - sz;
    nack = 0; run = 1; eack = '0;
    for (int i = 0; i < 2; i++) begin
      run = run && ps[i];
      if (run && i < fr && !rs && !fl) begin eack[i] = 1'b1; nack++; end
    end
    nret = 0; run = 1;
    for (int i = 0; i < 2; i++) begin
      run = run && rt[i];
      if (run && nret < sz) nret++;
    end
    if (rs || fl) nret = 0;
    evld = '0; eidx = '0;
    for (int j = 0; j < 8; j++) begin
      eidx[j*3 +: 3] = 3'((m_rd + j) % 8);
      if (j < sz) begin
        evld[j] = mq_vld[j]; edat = mq_data[j];
      end else if (j - sz < nack) begin
        evld[j] = 1'b1; edat = d[j - sz];
      end else edat = '0;
      if (j < sz + nack) check($sformatf("ent_data[%0d]", j), 64'(ent_data[j*32 +: 32]), 64'(edat));
    end
    check("push_ack", 64'(push_ack), 64'(eack));
    check("ent_vld", 64'(ent_vld), 64'(evld));
    check("ent_idx", 64'(ent_idx), 64'(eidx));
    check("count", 64'(count), 64'(sz));
    check("free", 64'(free), 64'(fr));
    for (int k = 0; k < nret; k++) begin
      if (sb_q.size() == 0) check("retire_sb_empty", 64'(1), 64'(0));
      else check("retire_data", 64'(ent_data[k*32 +: 32]), 64'(sb_q.pop_front()));
    end
    @(posedge clk); #1;
    if (rs || fl) begin
      mq_data.delete(); mq_vld.delete(); sb_q.delete(); m_rd = 0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (eack[i]) begin mq_data.push_back(d[i]); mq_vld.push_back(1'b1); sb_q.push_back(d[i]); end
      for (int p = 0; p < 2; p++) begin
        key = (p == 0) ? int'(k0) : int'(k1);
        if (pp[p] && (key < sz || (key - sz) < nack)) mq_vld[key] = 1'b0;
      end
      for (int k = 0; k < nret; k++) begin
        void'(mq_data.pop_front()); void'(mq_vld.pop_front());
      end
      m_rd = (m_rd + nret) % 8;
    end
  endtask

  task automatic idle();
    cycle(2'b00, 32'h0, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    push = '0; push_data = '0; pop = '0; pop_key = '0; retire = '0; flush = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // T1 reset holds off pushes
    cycle(2'b11, 32'hDEAD0001, 32'hDEAD0002, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1);
    // T2 dual push
    cycle(2'b11, 32'hAAAA0001, 32'hBBBB0002, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    idle();
    // T3 fill to full, then retire frees a slot only for the next cycle
    cycle(2'b11, 32'h30000003, 32'h30000004, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h30000005, 32'h30000006, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b01, 32'h30000007, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h30000008, 32'h30000009, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b01, 32'h3000000A, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b01, 32'h3000000B, 32'h0, 2'b00, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
    cycle(2'b01, 32'h3000000C, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    idle();
    cycle(2'b00, 32'h0, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    // T4 issue of a bypassed push
    cycle(2'b01, 32'hC0C0C0C0, 32'h0, 2'b01, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    idle();
    cycle(2'b00, 32'h0, 32'h0, 2'b00, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
    // T5 wrap with steady push/retire and occasional issue
    for (int c = 0; c < 20; c++)
      cycle(2'b11, $urandom, $urandom, 2'((c % 3) == 0 ? 1 : 0), 3'($urandom_range(0, 3)), 3'd0,
            (mq_data.size() >= 2) ? 2'b11 : 2'b00, 1'b0, 1'b0);
    idle();
    // T6 flush mid-operation overrides push and pop
    cycle(2'b00, 32'h0, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    cycle(2'b11, 32'h60000001, 32'h60000002, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h60000003, 32'h60000004, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b01, 32'h60000005, 32'h0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h60000006, 32'h60000007, 2'b11, 3'd1, 3'd2, 2'b00, 1'b1, 1'b0);
    idle();
    // Random mix including non-contiguous request vectors and duplicate keys
    for (int c = 0; c < 60; c++)
      cycle(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), 1'b0);
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
